// File: rtl/alu_operand_collector_if.sv
// Operand-collector bus: driver-side inputs, staged operand set and status toward the ALU stage.
interface alu_operand_collector_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 3,
    parameter int TIMEOUT   = 16
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic                 ce;
    logic [1:0]           inp_valid;
    logic [WIDTH-1:0]     opa_in;
    logic [WIDTH-1:0]     opb_in;
    logic [CMD_WIDTH:0]   cmd_in;
    logic                 mode_in;
    logic                 cin_in;
    logic [WIDTH-1:0]     opa_out;
    logic [WIDTH-1:0]     opb_out;
    logic [CMD_WIDTH:0]   cmd_out;
    logic                 mode_out;
    logic                 cin_out;
    logic                 op_valid;
    logic                 err;
    logic                 busy;
    logic [CNT_W-1:0]     wait_cnt;

    modport master (
        output ce, inp_valid, opa_in, opb_in, cmd_in, mode_in, cin_in,
        input  opa_out, opb_out, cmd_out, mode_out, cin_out, op_valid, err, busy, wait_cnt
    );

    modport slave (
        input  ce, inp_valid, opa_in, opb_in, cmd_in, mode_in, cin_in,
        output opa_out, opb_out, cmd_out, mode_out, cin_out, op_valid, err, busy, wait_cnt
    );
endinterface

// File: rtl/alu_operand_collector.sv
// Collects OPA/OPB arriving on separate cycles into one registered operand set,
// with a bounded wait window for the partner operand.
module alu_operand_collector #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_operand_collector_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

    state_t             state_q,   state_nxt;
    logic [CNT_W-1:0]   cnt_q,     cnt_nxt;
    // Only one operand is ever pending, so a single hold register serves both waits.
    logic [WIDTH-1:0]   hold_op_q, hold_op_nxt;
    logic [CMD_WIDTH:0] hold_cmd_q, hold_cmd_nxt;
    logic               hold_mode_q, hold_mode_nxt;
    logic               hold_cin_q, hold_cin_nxt;
    logic [WIDTH-1:0]   opa_q,  opa_nxt;
    logic [WIDTH-1:0]   opb_q,  opb_nxt;
    logic [CMD_WIDTH:0] cmd_q,  cmd_nxt;
    logic               mode_q, mode_nxt;
    logic               cin_q,  cin_nxt;
    logic               valid_q, valid_nxt;
    logic               err_q,   err_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_op_q   <= '0;
            hold_cmd_q  <= '0;
            hold_mode_q <= 1'b0;
            hold_cin_q  <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.ce) begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            hold_op_q   <= hold_op_nxt;
            hold_cmd_q  <= hold_cmd_nxt;
            hold_mode_q <= hold_mode_nxt;
            hold_cin_q  <= hold_cin_nxt;
            opa_q       <= opa_nxt;
            opb_q       <= opb_nxt;
            cmd_q       <= cmd_nxt;
            mode_q      <= mode_nxt;
            cin_q       <= cin_nxt;
            valid_q     <= valid_nxt;
            err_q       <= err_nxt;
        end else begin
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        hold_op_nxt   = hold_op_q;
        hold_cmd_nxt  = hold_cmd_q;
        hold_mode_nxt = hold_mode_q;
        hold_cin_nxt  = hold_cin_q;
        opa_nxt       = opa_q;
        opb_nxt       = opb_q;
        cmd_nxt       = cmd_q;
        mode_nxt      = mode_q;
        cin_nxt       = cin_q;
        valid_nxt     = 1'b0;
        err_nxt       = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (bus.inp_valid)
                    2'b11: begin
                        opa_nxt   = bus.opa_in;
                        opb_nxt   = bus.opb_in;
                        cmd_nxt   = bus.cmd_in;
                        mode_nxt  = bus.mode_in;
                        cin_nxt   = bus.cin_in;
                        valid_nxt = 1'b1;
                    end
                    2'b01, 2'b10: begin
                        hold_op_nxt   = bus.inp_valid[0] ? bus.opa_in : bus.opb_in;
                        hold_cmd_nxt  = bus.cmd_in;
                        hold_mode_nxt = bus.mode_in;
                        hold_cin_nxt  = bus.cin_in;
                        cnt_nxt       = '0;
                        state_nxt     = bus.inp_valid[0] ? WAIT_B : WAIT_A;
                    end
                    default: ;
                endcase
            end
            WAIT_A, WAIT_B: begin
                if (bus.inp_valid == 2'b11) begin
                    opa_nxt   = bus.opa_in;
                    opb_nxt   = bus.opb_in;
                    cmd_nxt   = bus.cmd_in;
                    mode_nxt  = bus.mode_in;
                    cin_nxt   = bus.cin_in;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if ((state_q == WAIT_B && bus.inp_valid == 2'b10) ||
                             (state_q == WAIT_A && bus.inp_valid == 2'b01)) begin
                    opa_nxt   = (state_q == WAIT_B) ? hold_op_q : bus.opa_in;
                    opb_nxt   = (state_q == WAIT_B) ? bus.opb_in : hold_op_q;
                    cmd_nxt   = hold_cmd_q;
                    mode_nxt  = hold_mode_q;
                    cin_nxt   = hold_cin_q;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    // A repeat of the already-held operand refreshes it without restarting the window.
                    if (bus.inp_valid != 2'b00) begin
                        hold_op_nxt = (state_q == WAIT_B) ? bus.opa_in : bus.opb_in;
                    end
                    if (cnt_q == LAST) begin
                        err_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.opa_out  = opa_q;
    assign bus.opb_out  = opb_q;
    assign bus.cmd_out  = cmd_q;
    assign bus.mode_out = mode_q;
    assign bus.cin_out  = cin_q;
    assign bus.op_valid = valid_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.wait_cnt = cnt_q;
endmodule
